// File: rtl/button_conditioner_pkg.sv
`default_nettype none
// ============================================================================
// Module      : btn_pkg
// Description : Shared types and constants for the push-button conditioner:
//               FSM state encoding, counter width and short simulation
//               parameter values.
// Revision    : 1.0 - initial release
// ============================================================================
package btn_pkg;

    // Width of the debounce and hold counters
    localparam int CNT_W = 32;

    // Short timing values used when simulating the conditioner
    localparam logic [31:0] DEB_SIM  = 32'd4;
    localparam logic [31:0] LONG_SIM = 32'd16;

    // Conditioner FSM states
    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        PRESS_WAIT   = 2'd1,
        HELD         = 2'd2,
        RELEASE_WAIT = 2'd3
    } btn_state_t;

endpackage : btn_pkg
`default_nettype wire

// File: rtl/button_conditioner_sync_2ff.sv
`default_nettype none
// ============================================================================
// Module      : sync_2ff
// Description : One-bit two-flop synchroniser for asynchronous pin inputs.
//               Both flops clear to 0 on an asynchronous active-high reset.
// Revision    : 1.0 - initial release
// ============================================================================
module sync_2ff (
    input  logic clk,
    input  logic rst,
    input  logic i_d,
    output logic o_q
);

    logic r_s1;
    logic r_s2;

    // Two-stage capture of the asynchronous input into the clk domain
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1 <= 1'b0;
            r_s2 <= 1'b0;
        end else begin
            r_s1 <= i_d;
            r_s2 <= r_s1;
        end
    end

    assign o_q = r_s2;

endmodule : sync_2ff
`default_nettype wire

// File: rtl/button_conditioner.sv
`default_nettype none
// ============================================================================
// Module      : button_conditioner
// Description : Turns a raw, bouncing push-button into a debounced level,
//               single-cycle press/release/long-hold pulses and a run/stop
//               control bit for downstream LED pattern blocks.
// Revision    : 1.0 - initial release
// ============================================================================
module button_conditioner
    import btn_pkg::*;
#(
    parameter logic [31:0] DEBOUNCE_CYCLES = 32'd2_000_000,
    parameter logic [31:0] LONG_CYCLES     = 32'd100_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_raw,
    output logic pressed,
    output logic press_pulse,
    output logic release_pulse,
    output logic long_pulse,
    output logic run
);

    // Terminal counts for the debounce window and the long-hold threshold
    localparam logic [CNT_W-1:0] c_deb_last  = CNT_W'(DEBOUNCE_CYCLES - 32'd1);
    localparam logic [CNT_W-1:0] c_long_last = CNT_W'(LONG_CYCLES - 32'd1);

    logic             w_btn_sync;
    logic [CNT_W-1:0] w_hold_inc;
    btn_state_t       r_state;
    logic [CNT_W-1:0] r_deb_cnt;
    logic [CNT_W-1:0] r_hold_cnt;

    sync_2ff u_sync (
        .clk (clk),
        .rst (rst),
        .i_d (btn_raw),
        .o_q (w_btn_sync)
    );

    assign w_hold_inc = r_hold_cnt + CNT_W'(1);

    // Debounce FSM; all outputs are registered here so that run changes in
    // the same cycle as the pulse that drives it
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= IDLE;
            r_deb_cnt     <= '0;
            r_hold_cnt    <= '0;
            pressed       <= 1'b0;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
            long_pulse    <= 1'b0;
            run           <= 1'b0;
        end else begin
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
            long_pulse    <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_btn_sync) begin
                        r_state   <= PRESS_WAIT;
                        r_deb_cnt <= '0;
                    end
                end
                PRESS_WAIT: begin
                    if (!w_btn_sync) begin
                        r_state <= IDLE;
                    end else if (r_deb_cnt == c_deb_last) begin
                        r_state     <= HELD;
                        pressed     <= 1'b1;
                        press_pulse <= 1'b1;
                        r_hold_cnt  <= '0;
                        run         <= ~run;
                    end else begin
                        r_deb_cnt <= r_deb_cnt + CNT_W'(1);
                    end
                end
                HELD: begin
                    if (!w_btn_sync) begin
                        r_state   <= RELEASE_WAIT;
                        r_deb_cnt <= '0;
                    end else if (r_hold_cnt < c_long_last) begin
                        // Saturating count; the pulse fires only on the step
                        // that reaches the threshold, so once per press
                        r_hold_cnt <= w_hold_inc;
                        if (w_hold_inc == c_long_last) begin
                            long_pulse <= 1'b1;
                            run        <= 1'b0;
                        end
                    end
                end
                RELEASE_WAIT: begin
                    if (w_btn_sync) begin
                        // Release bounce: resume the hold with its count kept
                        r_state <= HELD;
                    end else if (r_deb_cnt == c_deb_last) begin
                        r_state       <= IDLE;
                        pressed       <= 1'b0;
                        release_pulse <= 1'b1;
                    end else begin
                        r_deb_cnt <= r_deb_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule : button_conditioner
`default_nettype wire

// File: tb/tb_button_conditioner.sv
`default_nettype none
// ============================================================================
// Module      : tb_button_conditioner
// Description : Self-checking bench for button_conditioner using per-cycle
//               vector tables plus hand-written reset sequences.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_button_conditioner;
    import btn_pkg::*;

    // Expected-output bit order: {pressed, press_pulse, release_pulse, long_pulse, run}
    typedef struct {
        logic       raw;
        logic [4:0] exp;
    } vec_t;

    logic clk;
    logic rst;
    logic btn_raw;
    logic pressed;
    logic press_pulse;
    logic release_pulse;
    logic long_pulse;
    logic run;
    logic [4:0] w_outs;

    int checks;
    int failures;
    vec_t vecs[$];

    button_conditioner #(
        .DEBOUNCE_CYCLES (DEB_SIM),
        .LONG_CYCLES     (LONG_SIM)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .btn_raw       (btn_raw),
        .pressed       (pressed),
        .press_pulse   (press_pulse),
        .release_pulse (release_pulse),
        .long_pulse    (long_pulse),
        .run           (run)
    );

    assign w_outs = {pressed, press_pulse, release_pulse, long_pulse, run};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [4:0] act, input logic [4:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got {pr,pp,rp,lp,run}=%b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void add(input logic raw, input logic [4:0] exp, input int n);
        vec_t v;
        v.raw = raw;
        v.exp = exp;
        for (int i = 0; i < n; i++) vecs.push_back(v);
    endfunction

    // After rst is released mid-cycle with the button held, the first posedge
    // is the capture edge; press_pulse must appear after its sixth successor
    task automatic check_repress(input string name);
        for (int i = 0; i < 8; i++) begin
            tick();
            if (i < 6)       check(name, w_outs, 5'b00000);
            else if (i == 6) check(name, w_outs, 5'b11001);
            else             check(name, w_outs, 5'b10001);
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;

        // Clean press held 40 cycles: press at +6, long at +21, release 6 after fall
        add(1'b1, 5'b00000, 6);
        add(1'b1, 5'b11001, 1);
        add(1'b1, 5'b10001, 14);
        add(1'b1, 5'b10010, 1);
        add(1'b1, 5'b10000, 18);
        add(1'b0, 5'b10000, 6);
        add(1'b0, 5'b00100, 1);
        add(1'b0, 5'b00000, 2);
        // Press bounce: 3 high, 2 low, 2 high, low -> nothing
        add(1'b1, 5'b00000, 3);
        add(1'b0, 5'b00000, 2);
        add(1'b1, 5'b00000, 2);
        add(1'b0, 5'b00000, 4);
        // Release bounce during hold: 3 stalled cycles delay long to +24
        add(1'b1, 5'b00000, 6);
        add(1'b1, 5'b11001, 1);
        add(1'b1, 5'b10001, 3);
        add(1'b0, 5'b10001, 2);
        add(1'b1, 5'b10001, 12);
        add(1'b1, 5'b10010, 1);
        add(1'b1, 5'b10000, 5);
        add(1'b0, 5'b10000, 6);
        add(1'b0, 5'b00100, 1);
        add(1'b0, 5'b00000, 2);
        // Two short presses: run 0 -> 1 -> 0
        add(1'b1, 5'b00000, 6);
        add(1'b1, 5'b11001, 1);
        add(1'b1, 5'b10001, 1);
        add(1'b0, 5'b10001, 6);
        add(1'b0, 5'b00101, 1);
        add(1'b0, 5'b00001, 3);
        add(1'b1, 5'b00001, 6);
        add(1'b1, 5'b11000, 1);
        add(1'b1, 5'b10000, 1);
        add(1'b0, 5'b10000, 6);
        add(1'b0, 5'b00100, 1);
        add(1'b0, 5'b00000, 3);

        rst     = 1'b1;
        btn_raw = 1'b0;
        repeat (3) tick();
        check("reset_state", w_outs, 5'b00000);
        @(negedge clk);
        rst = 1'b0;

        foreach (vecs[i]) begin
            btn_raw = vecs[i].raw;
            tick();
            check($sformatf("vec%0d", i), w_outs, vecs[i].exp);
        end

        // Reset while HELD with run=1
        btn_raw = 1'b1;
        repeat (7) tick();
        check("held_press", w_outs, 5'b11001);
        repeat (2) tick();
        check("held_level", w_outs, 5'b10001);
        #2 rst = 1'b1;
        #1 check("rst_in_held", w_outs, 5'b00000);
        repeat (2) tick();
        check("rst_hold_held", w_outs, 5'b00000);
        @(negedge clk);
        rst = 1'b0;
        check_repress("repress_after_held_rst");

        // Release, then reset in PRESS_WAIT with deb_cnt=2 and run=1
        btn_raw = 1'b0;
        repeat (12) tick();
        check("idle_run", w_outs, 5'b00001);
        btn_raw = 1'b1;
        repeat (5) tick();
        check("press_wait_quiet", w_outs, 5'b00001);
        #2 rst = 1'b1;
        #1 check("rst_in_press_wait", w_outs, 5'b00000);
        repeat (2) tick();
        @(negedge clk);
        rst = 1'b0;
        check_repress("repress_after_pw_rst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_button_conditioner
`default_nettype wire
